pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'h0040_0000, PC value loaded on reset.
REQ-002 iCLK  input  1  system clock; all state changes on rising edge.
REQ-003 iRST  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 oFetchReq  output  1  instruction fetch request; held high until acknowledged.
REQ-005 iFetchAck  input  1  fetch acknowledge; iInstr valid in the same cycle.
REQ-006 iInstr  input  32  fetched instruction word.
REQ-007 iRs1Data, iRs2Data  input  32 each  register operands, stable during EXEC.
REQ-008 oPC  output  32  current PC; also the fetch address.
REQ-009 oCOrigPC  output  2  PC-source class of the latched instruction: 00 normal, 01 branch, 10 JAL, 11 JALR.
REQ-010 oTaken  output  1  transfer decision for the latched instruction, valid in UPDATE.
REQ-011 oLinkWrite  output  1  one-cycle pulse in UPDATE for JAL/JALR; oLinkData = old PC+4.
REQ-012 oLinkData  output  32  link value.
REQ-013 oRetire  output  1  one-cycle pulse when PC update commits.
REQ-014 oTrap  output  1  sticky misaligned-target flag.

Function
REQ-015 FSM states FETCH, DECODE, EXEC, UPDATE, TRAP; FETCH is the post-reset state.
REQ-016 FETCH: oFetchReq=1; on iFetchAck latch iInstr, go DECODE; otherwise stay.
REQ-017 DECODE (1 cycle): classify opcode 1100011->01, 1101111->10, 1100111->11, all others->00; latch class and sign-extended B/J/I immediate.
REQ-018 EXEC (1 cycle): sample iRs1Data/iRs2Data; compute condition and target.
REQ-019 Branch funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 not taken.
REQ-020 Targets: branch/JAL = PC + imm; JALR = (rs1 + imm) with bit 0 cleared; class 00 and not-taken = PC+4; all sums modulo 2^32.
REQ-021 Taken = 1 for JAL/JALR, condition result for branch, 0 for class 00.
REQ-022 If taken and target[1:0] != 00: go TRAP, PC unchanged, no oRetire, no oLinkWrite.
REQ-023 UPDATE (1 cycle): PC <= next PC, oRetire=1, oLinkWrite=1 for JAL/JALR, then FETCH.
REQ-024 Fixed latency: 4 cycles per instruction when iFetchAck asserted in first FETCH cycle.
REQ-025 TRAP: oTrap=1, oFetchReq=0, all pulses 0; exit only by reset.
REQ-026 iFetchAck outside FETCH ignored.
REQ-027 oCOrigPC and oTaken hold their values from DECODE until the next DECODE.

Reset
REQ-028 During iRST: state FETCH, oPC=RESET_PC, oCOrigPC=00, oTaken=0, oLinkWrite=0, oLinkData=0, oRetire=0, oTrap=0, oFetchReq=1 after release.
REQ-029 Reset mid-instruction aborts it: no retire, no link write, PC returns to RESET_PC.

Verification
REQ-030 ADDI at 0x0040_0000, ack immediately -> oRetire in cycle 4, oPC=0x0040_0004, oCOrigPC=00.
REQ-031 BEQ imm=-8, rs1=rs2=5 at 0x0040_0010 -> oTaken=1, oPC=0x0040_0008; rs2=6 -> oPC=0x0040_0014.
REQ-032 BLT rs1=0xFFFF_FFFF, rs2=1 -> taken; BLTU same operands -> not taken.
REQ-033 JALR rs1=0x0040_0101, imm=0 at 0x0040_0020 -> oPC=0x0040_0100, oLinkWrite pulse, oLinkData=0x0040_0024.
REQ-034 JALR rs1=0x0040_0102 -> oTrap=1, oPC unchanged, oFetchReq=0 until iRST.
REQ-035 iFetchAck delayed 3 cycles, then iRST asserted in EXEC -> no oRetire, oPC=RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Purpose : multi-cycle PC sequencer (FETCH/DECODE/EXEC/UPDATE) with branch, JAL and JALR resolution.
// Latency : 4 cycles per instruction when the fetch is acknowledged in the first FETCH cycle.
// Backpr. : stalls in FETCH until iFetchAck; a misaligned taken target parks it in TRAP until iRST.
//
// Ports:
//   iCLK, iRST           clock, asynchronous active-high reset
//   oFetchReq/iFetchAck  fetch handshake, iInstr valid with iFetchAck
//   iRs1Data/iRs2Data    register operands, sampled in EXEC
//   oPC                  current PC / fetch address
//   oCOrigPC, oTaken     PC-source class and transfer decision of the latched instruction
//   oLinkWrite/oLinkData link register write pulse and value (old PC + 4)
//   oRetire              pulse in the cycle the PC update commits
//   oTrap                sticky misaligned-target flag
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    output logic        oFetchReq,
    input  logic        iFetchAck,
    input  logic [31:0] iInstr,
    input  logic [31:0] iRs1Data,
    input  logic [31:0] iRs2Data,
    output logic [31:0] oPC,
    output logic [1:0]  oCOrigPC,
    output logic        oTaken,
    output logic        oLinkWrite,
    output logic [31:0] oLinkData,
    output logic        oRetire,
    output logic        oTrap
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_UPDATE = 3'd3,
        S_TRAP   = 3'd4
    } state_t;

    localparam logic [1:0] C_NORMAL = 2'b00;
    localparam logic [1:0] C_BRANCH = 2'b01;
    localparam logic [1:0] C_JAL    = 2'b10;
    localparam logic [1:0] C_JALR   = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [1:0]  class_q;
    logic [31:0] imm_q;
    logic        taken_q;
    logic [31:0] next_pc_q;
    logic [31:0] link_q;

    // Decode of the latched instruction word
    logic [1:0]  dec_class;
    logic [31:0] dec_imm;
    logic [31:0] imm_i, imm_b, imm_j;

    assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

    always_comb begin
        dec_class = C_NORMAL;
        dec_imm   = imm_i;
        case (instr_q[6:0])
            7'b1100011: begin dec_class = C_BRANCH; dec_imm = imm_b; end
            7'b1101111: begin dec_class = C_JAL;    dec_imm = imm_j; end
            7'b1100111: begin dec_class = C_JALR;   dec_imm = imm_i; end
            default:    begin dec_class = C_NORMAL; dec_imm = imm_i; end
        endcase
    end

    // Execute: condition and target from the operands present during EXEC
    logic [31:0] pc_plus4;
    logic [31:0] rel_target;
    logic [31:0] jalr_target;
    logic [31:0] exec_target;
    logic        cond;
    logic        exec_taken;
    logic        misaligned;

    assign pc_plus4    = pc_q + 32'd4;
    assign rel_target  = pc_q + imm_q;
    assign jalr_target = (iRs1Data + imm_q) & ~32'd1;
    assign exec_target = (class_q == C_JALR) ? jalr_target : rel_target;

    always_comb begin
        cond = 1'b0;
        case (instr_q[14:12])
            3'b000:  cond = (iRs1Data == iRs2Data);
            3'b001:  cond = (iRs1Data != iRs2Data);
            3'b100:  cond = ($signed(iRs1Data) <  $signed(iRs2Data));
            3'b101:  cond = ($signed(iRs1Data) >= $signed(iRs2Data));
            3'b110:  cond = (iRs1Data <  iRs2Data);
            3'b111:  cond = (iRs1Data >= iRs2Data);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        exec_taken = 1'b0;
        case (class_q)
            C_BRANCH: exec_taken = cond;
            C_JAL:    exec_taken = 1'b1;
            C_JALR:   exec_taken = 1'b1;
            default:  exec_taken = 1'b0;
        endcase
    end

    // Only a transfer that is actually taken can fault; not-taken falls through to PC+4.
    assign misaligned = exec_taken && (exec_target[1:0] != 2'b00);

    // FSM: state register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = iFetchAck ? S_DECODE : S_FETCH;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = misaligned ? S_TRAP : S_UPDATE;
            S_UPDATE: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // FSM: outputs
    always_comb begin
        oFetchReq  = 1'b0;
        oRetire    = 1'b0;
        oLinkWrite = 1'b0;
        oTrap      = 1'b0;
        case (state_q)
            S_FETCH:  oFetchReq = 1'b1;
            S_UPDATE: begin
                oRetire    = 1'b1;
                oLinkWrite = class_q[1];
            end
            S_TRAP:   oTrap = 1'b1;
            default:  ;
        endcase
    end

    // Datapath registers, advanced per state
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            class_q   <= C_NORMAL;
            imm_q     <= 32'd0;
            taken_q   <= 1'b0;
            next_pc_q <= 32'd0;
            link_q    <= 32'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (iFetchAck) begin
                        instr_q <= iInstr;
                    end
                end
                S_DECODE: begin
                    class_q <= dec_class;
                    imm_q   <= dec_imm;
                    taken_q <= 1'b0;
                end
                S_EXEC: begin
                    taken_q   <= exec_taken;
                    next_pc_q <= exec_taken ? exec_target : pc_plus4;
                    if (class_q[1] && !misaligned) begin
                        link_q <= pc_plus4;
                    end
                end
                S_UPDATE: begin
                    pc_q <= next_pc_q;
                end
                default: ;
            endcase
        end
    end

    assign oPC       = pc_q;
    assign oCOrigPC  = class_q;
    assign oTaken    = taken_q;
    assign oLinkData = link_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        oFetchReq;
    logic        iFetchAck = 1'b0;
    logic [31:0] iInstr = 32'd0;
    logic [31:0] iRs1Data = 32'd0;
    logic [31:0] iRs2Data = 32'd0;
    logic [31:0] oPC;
    logic [1:0]  oCOrigPC;
    logic        oTaken;
    logic        oLinkWrite;
    logic [31:0] oLinkData;
    logic        oRetire;
    logic        oTrap;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .oFetchReq  (oFetchReq),
        .iFetchAck  (iFetchAck),
        .iInstr     (iInstr),
        .iRs1Data   (iRs1Data),
        .iRs2Data   (iRs2Data),
        .oPC        (oPC),
        .oCOrigPC   (oCOrigPC),
        .oTaken     (oTaken),
        .oLinkWrite (oLinkWrite),
        .oLinkData  (oLinkData),
        .oRetire    (oRetire),
        .oTrap      (oTrap)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;
    int retire_cnt = 0;
    int link_cnt   = 0;

    always @(negedge iCLK) begin
        if (oRetire)    retire_cnt++;
        if (oLinkWrite) link_cnt++;
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  cls;
        logic        taken;
        logic        link;
        logic [31:0] link_data;
        logic [31:0] pc_after;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [6:0] op);
        return {imm, 5'd1, 3'b000, 5'd1, op};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one instruction from a FETCH cycle; iFetchAck stays high with a decoy JAL
    // word after the real acknowledge, which the sequencer must ignore.
    task automatic run_vec(input vec_t v, input int delay, input int idx);
        int cyc;
        int guard;
        cyc = 1;
        guard = 0;
        iRs1Data = v.rs1;
        iRs2Data = v.rs2;
        check($sformatf("v%0d fetch_req", idx), {31'd0, oFetchReq}, 32'd1);
        iFetchAck = 1'b0;
        repeat (delay) begin
            @(negedge iCLK);
            cyc++;
        end
        iFetchAck = 1'b1;
        iInstr    = v.instr;
        @(negedge iCLK);
        cyc++;
        iInstr = 32'h0000_006F;
        while (!(oRetire || oTrap) && guard < 12) begin
            @(negedge iCLK);
            cyc++;
            guard++;
        end
        iFetchAck = 1'b0;
        check($sformatf("v%0d retire", idx), {31'd0, oRetire}, 32'd1);
        check($sformatf("v%0d latency", idx), cyc, delay + 4);
        check($sformatf("v%0d class", idx), {30'd0, oCOrigPC}, {30'd0, v.cls});
        check($sformatf("v%0d taken", idx), {31'd0, oTaken}, {31'd0, v.taken});
        check($sformatf("v%0d link_write", idx), {31'd0, oLinkWrite}, {31'd0, v.link});
        if (v.link) check($sformatf("v%0d link_data", idx), oLinkData, v.link_data);
        @(negedge iCLK);
        check($sformatf("v%0d pc", idx), oPC, v.pc_after);
        check($sformatf("v%0d class_hold", idx), {30'd0, oCOrigPC}, {30'd0, v.cls});
        check($sformatf("v%0d taken_hold", idx), {31'd0, oTaken}, {31'd0, v.taken});
        check($sformatf("v%0d retire_pulse", idx), {31'd0, oRetire}, 32'd0);
    endtask

    initial begin
        int guard;
        vec_t v;

        //          instr                                     rs1           rs2          cls    tk    lk    link_data     pc_after
        vecs[0]  = '{enc_i(12'd1, 7'b0010011),                 32'd0,        32'd0,       2'b00, 1'b0, 1'b0, 32'd0,        32'h0040_0004};
        vecs[1]  = '{enc_j(21'd12),                            32'd0,        32'd0,       2'b10, 1'b1, 1'b1, 32'h0040_0008, 32'h0040_0010};
        vecs[2]  = '{enc_b(13'h1FF8, 3'b000),                  32'd5,        32'd5,       2'b01, 1'b1, 1'b0, 32'd0,        32'h0040_0008};
        vecs[3]  = '{enc_j(21'd8),                             32'd0,        32'd0,       2'b10, 1'b1, 1'b1, 32'h0040_000C, 32'h0040_0010};
        vecs[4]  = '{enc_b(13'h1FF8, 3'b000),                  32'd5,        32'd6,       2'b01, 1'b0, 1'b0, 32'd0,        32'h0040_0014};
        vecs[5]  = '{enc_b(13'd8, 3'b100),                     32'hFFFF_FFFF, 32'd1,      2'b01, 1'b1, 1'b0, 32'd0,        32'h0040_001C};
        vecs[6]  = '{enc_b(13'd8, 3'b110),                     32'hFFFF_FFFF, 32'd1,      2'b01, 1'b0, 1'b0, 32'd0,        32'h0040_0020};
        vecs[7]  = '{enc_i(12'd0, 7'b1100111),                 32'h0040_0101, 32'd0,      2'b11, 1'b1, 1'b1, 32'h0040_0024, 32'h0040_0100};
        vecs[8]  = '{enc_b(13'd16, 3'b001),                    32'd3,        32'd4,       2'b01, 1'b1, 1'b0, 32'd0,        32'h0040_0110};
        vecs[9]  = '{enc_b(13'h1FF0, 3'b101),                  32'h8000_0000, 32'd0,      2'b01, 1'b0, 1'b0, 32'd0,        32'h0040_0114};
        vecs[10] = '{enc_b(13'd4, 3'b111),                     32'h8000_0000, 32'd0,      2'b01, 1'b1, 1'b0, 32'd0,        32'h0040_0118};
        vecs[11] = '{enc_b(13'd8, 3'b010),                     32'd7,        32'd7,       2'b01, 1'b0, 1'b0, 32'd0,        32'h0040_011C};
        vecs[12] = '{enc_i(12'hFFC, 7'b1100111),               32'h0040_0000, 32'd0,      2'b11, 1'b1, 1'b1, 32'h0040_0120, 32'h003F_FFFC};
        vecs[13] = '{enc_b(13'd6, 3'b000),                     32'd1,        32'd2,       2'b01, 1'b0, 1'b0, 32'd0,        32'h0040_0000};

        // Reset values
        repeat (2) @(negedge iCLK);
        check("rst pc", oPC, RST_PC);
        check("rst class", {30'd0, oCOrigPC}, 32'd0);
        check("rst taken", {31'd0, oTaken}, 32'd0);
        check("rst link_write", {31'd0, oLinkWrite}, 32'd0);
        check("rst link_data", oLinkData, 32'd0);
        check("rst retire", {31'd0, oRetire}, 32'd0);
        check("rst trap", {31'd0, oTrap}, 32'd0);
        iRST = 1'b0;
        #1;
        check("rel fetch_req", {31'd0, oFetchReq}, 32'd1);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], i % 3, i);
        end

        // Misaligned JALR target traps with the PC untouched
        iRs1Data  = 32'h0040_0102;
        iRs2Data  = 32'd0;
        iFetchAck = 1'b1;
        iInstr    = enc_i(12'd0, 7'b1100111);
        @(negedge iCLK);
        iInstr = 32'h0000_006F;
        guard = 0;
        while (!(oTrap || oRetire) && guard < 12) begin
            @(negedge iCLK);
            guard++;
        end
        check("trap flag", {31'd0, oTrap}, 32'd1);
        check("trap retire", {31'd0, oRetire}, 32'd0);
        check("trap link_write", {31'd0, oLinkWrite}, 32'd0);
        check("trap fetch_req", {31'd0, oFetchReq}, 32'd0);
        check("trap pc", oPC, 32'h0040_0000);
        repeat (5) @(negedge iCLK);
        check("trap sticky", {31'd0, oTrap}, 32'd1);
        check("trap sticky fetch_req", {31'd0, oFetchReq}, 32'd0);
        check("trap sticky pc", oPC, 32'h0040_0000);
        iFetchAck = 1'b0;

        // Reset leaves TRAP and clears link data
        iRST = 1'b1;
        #1;
        check("trap rst flag", {31'd0, oTrap}, 32'd0);
        check("trap rst link_data", oLinkData, 32'd0);
        check("trap rst class", {30'd0, oCOrigPC}, 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        #1;
        check("trap rel fetch_req", {31'd0, oFetchReq}, 32'd1);

        // Ack delayed 3 cycles, reset arrives in EXEC: instruction aborted
        iRs1Data = 32'd0;
        repeat (3) @(negedge iCLK);
        check("abort fetch_wait pc", oPC, RST_PC);
        iFetchAck = 1'b1;
        iInstr    = enc_j(21'd16);
        @(negedge iCLK);
        iFetchAck = 1'b0;
        iInstr    = 32'd0;
        @(negedge iCLK);
        check("abort exec class", {30'd0, oCOrigPC}, 32'b10);
        iRST = 1'b1;
        #1;
        check("abort pc", oPC, RST_PC);
        check("abort retire", {31'd0, oRetire}, 32'd0);
        check("abort link_write", {31'd0, oLinkWrite}, 32'd0);
        check("abort class", {30'd0, oCOrigPC}, 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        #1;
        check("abort rel fetch_req", {31'd0, oFetchReq}, 32'd1);

        run_vec(vecs[0], 0, 100);

        @(negedge iCLK);
        check("retire count", retire_cnt, 15);
        check("link write count", link_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
